// File: rtl/omp_support_sink.sv
// Support-set collector at the receive end of the OMP core's lambda stream; hands the set to Block C.
// Optional duplicate-index rejection via a membership bitmap when OMP_SINK_DUPCHK_EN is defined.
module omp_support_sink #(
  parameter int IDX_W  = 6,
  parameter int ITER_W = 5,
  parameter int K_MAX  = 16,
  localparam int AW    = $clog2(K_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_omp,
  input  logic [ITER_W-1:0] K_limit,
  input  logic              lambda_we,
  input  logic [IDX_W-1:0]  lambda_out,
  input  logic [ITER_W-1:0] current_i_out,
  input  logic              done_omp,
  input  logic [ITER_W-1:0] final_i,
  input  logic [AW-1:0]     rd_addr,
  output logic [IDX_W-1:0]  rd_data,
  output logic [ITER_W-1:0] support_cnt,
  output logic              busy,
  output logic              blk_c_start,
  input  logic              blk_c_done,
  output logic              support_valid,
  output logic              err_order,
  output logic              err_ovf,
  output logic              err_dup
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HANDOFF, S_WAIT_C} state_t;

  state_t            state_q;
  logic [ITER_W-1:0] cnt_q, lim_q, lim_d, cnt_post;
  logic              done_prev_q, busy_q, bcs_q, valid_q;
  logic              err_order_q, err_ovf_q;
  logic [IDX_W-1:0]  rd_data_q;
  logic [IDX_W-1:0]  tbl_q [K_MAX];
  logic              in_order, room, dup, accept, done_rise;

`ifdef OMP_SINK_DUPCHK_EN
  logic [2**IDX_W-1:0] bmp_q;
  logic                err_dup_q;
  assign dup     = bmp_q[lambda_out];
  assign err_dup = err_dup_q;
`else
  assign dup     = 1'b0;
  assign err_dup = 1'b0;
`endif

  assign lim_d     = (K_limit > ITER_W'(K_MAX)) ? ITER_W'(K_MAX) : K_limit;
  assign in_order  = (current_i_out == cnt_q);
  assign room      = (cnt_q < lim_q);
  assign accept    = !start_omp && (state_q == S_COLLECT) && lambda_we && in_order && room && !dup;
  // Handoff compares final_i against the count including a same-cycle write.
  assign cnt_post  = accept ? cnt_q + ITER_W'(1) : cnt_q;
  assign done_rise = done_omp && !done_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lim_q       <= '0;
      done_prev_q <= 1'b0;
      busy_q      <= 1'b0;
      bcs_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_order_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      rd_data_q   <= '0;
`ifdef OMP_SINK_DUPCHK_EN
      bmp_q       <= '0;
      err_dup_q   <= 1'b0;
`endif
    end else begin
      done_prev_q <= done_omp;
      bcs_q       <= 1'b0;
      rd_data_q   <= tbl_q[rd_addr];
      if (start_omp) begin
        state_q     <= S_COLLECT;
        cnt_q       <= '0;
        lim_q       <= lim_d;
        busy_q      <= 1'b1;
        valid_q     <= 1'b0;
        err_order_q <= 1'b0;
        err_ovf_q   <= 1'b0;
`ifdef OMP_SINK_DUPCHK_EN
        bmp_q       <= '0;
        err_dup_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_COLLECT: begin
            if (accept) begin
              cnt_q <= cnt_post;
`ifdef OMP_SINK_DUPCHK_EN
              bmp_q[lambda_out] <= 1'b1;
`endif
            end else if (lambda_we) begin
              if (!in_order) err_order_q <= 1'b1;
              if (!room)     err_ovf_q   <= 1'b1;
`ifdef OMP_SINK_DUPCHK_EN
              if (dup)       err_dup_q   <= 1'b1;
`endif
            end
            if (done_rise) begin
              state_q <= S_HANDOFF;
              bcs_q   <= 1'b1;
              valid_q <= 1'b1;
              if (final_i != cnt_post) err_order_q <= 1'b1;
            end
          end
          S_HANDOFF: state_q <= S_WAIT_C;
          S_WAIT_C: begin
            if (blk_c_done) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Table storage carries no reset; slots beyond support_cnt are stale by definition.
  always_ff @(posedge clk) begin
    if (accept) tbl_q[cnt_q[AW-1:0]] <= lambda_out;
  end

  assign rd_data       = rd_data_q;
  assign support_cnt   = cnt_q;
  assign busy          = busy_q;
  assign blk_c_start   = bcs_q;
  assign support_valid = valid_q;
  assign err_order     = err_order_q;
  assign err_ovf       = err_ovf_q;

endmodule

// File: tb/tb_omp_support_sink.sv
// Randomized and directed bench for omp_support_sink against a transaction-level support-set model.
module tb_omp_support_sink;
  localparam int IDX_W = 6, ITER_W = 5, K_MAX = 16, AW = 4;
  localparam int M_IDLE = 0, M_COL = 1, M_HO = 2, M_WC = 3;

  logic clk = 1'b0, rst;
  logic start_omp, lambda_we, done_omp, blk_c_done;
  logic [ITER_W-1:0] K_limit, current_i_out, final_i, support_cnt;
  logic [IDX_W-1:0] lambda_out, rd_data;
  logic [AW-1:0] rd_addr;
  logic busy, blk_c_start, support_valid, err_order, err_ovf, err_dup;

  omp_support_sink #(.IDX_W(IDX_W), .ITER_W(ITER_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start_omp(start_omp), .K_limit(K_limit),
    .lambda_we(lambda_we), .lambda_out(lambda_out), .current_i_out(current_i_out),
    .done_omp(done_omp), .final_i(final_i), .rd_addr(rd_addr), .rd_data(rd_data),
    .support_cnt(support_cnt), .busy(busy), .blk_c_start(blk_c_start),
    .blk_c_done(blk_c_done), .support_valid(support_valid), .err_order(err_order),
    .err_ovf(err_ovf), .err_dup(err_dup));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: support set as a queue plus phase and sticky flags.
  int m_st, m_cnt, m_lim;
  int m_tbl[$];
  bit [63:0] m_seen;
  bit m_valid, m_eo, m_ev, m_ed, m_bcs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_lim = 0; m_tbl.delete(); m_seen = '0;
    m_valid = 0; m_eo = 0; m_ev = 0; m_ed = 0; m_bcs = 0;
  endtask

  task automatic cyc();
    if (m_st == M_HO) m_st = M_WC;
    m_bcs = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"},   32'(support_cnt),   32'(m_cnt));
    check({tag, ".busy"},  32'(busy),          32'(m_st != M_IDLE));
    check({tag, ".valid"}, 32'(support_valid), 32'(m_valid));
    check({tag, ".eord"},  32'(err_order),     32'(m_eo));
    check({tag, ".eovf"},  32'(err_ovf),       32'(m_ev));
    check({tag, ".edup"},  32'(err_dup),       32'(m_ed));
    check({tag, ".bcs"},   32'(blk_c_start),   32'(m_bcs));
  endtask

  task automatic model_write(input int i, input int idx);
    bit ok_ord, ok_room, is_dup;
    ok_ord  = (i == m_cnt);
    ok_room = (m_cnt < m_lim);
`ifdef OMP_SINK_DUPCHK_EN
    is_dup = m_seen[idx];
`else
    is_dup = 0;
`endif
    if (ok_ord && ok_room && !is_dup) begin
      m_tbl.push_back(idx); m_seen[idx] = 1; m_cnt++;
    end else begin
      if (!ok_ord)  m_eo = 1;
      if (!ok_room) m_ev = 1;
      if (is_dup)   m_ed = 1;
    end
  endtask

  task automatic do_start(input int k);
    start_omp = 1; K_limit = ITER_W'(k);
    cyc();
    start_omp = 0;
    model_reset();
    m_st = M_COL; m_lim = (k > K_MAX) ? K_MAX : k;
  endtask

  task automatic do_write(input int i, input int idx);
    int pre = m_st;
    lambda_we = 1; current_i_out = ITER_W'(i); lambda_out = IDX_W'(idx);
    cyc();
    lambda_we = 0;
    if (pre == M_COL) model_write(i, idx);
  endtask

  task automatic do_done(input int fi, input bit with_we, input int i, input int idx);
    int pre = m_st;
    done_omp = 1; final_i = ITER_W'(fi);
    if (with_we) begin
      lambda_we = 1; current_i_out = ITER_W'(i); lambda_out = IDX_W'(idx);
    end
    cyc();
    done_omp = 0; lambda_we = 0;
    if (pre == M_COL) begin
      if (with_we) model_write(i, idx);
      if (fi != m_cnt) m_eo = 1;
      m_st = M_HO; m_valid = 1; m_bcs = 1;
    end
  endtask

  task automatic do_blk();
    int pre = m_st;
    blk_c_done = 1;
    cyc();
    blk_c_done = 0;
    if (pre == M_WC) m_st = M_IDLE;
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < m_cnt; a++) begin
      rd_addr = AW'(a);
      cyc();
      check($sformatf("%s.rd%0d", tag, a), 32'(rd_data), 32'(m_tbl[a]));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nw, r, i, idx, fi;
    bit we;
    rst = 1; start_omp = 0; K_limit = '0; lambda_we = 0; lambda_out = '0;
    current_i_out = '0; done_omp = 0; final_i = '0; rd_addr = '0; blk_c_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_all("reset");
    check("reset.rd", 32'(rd_data), 32'd0);

    // 1: full in-order set, handoff, readback
    do_start(16);
    for (int n = 0; n < 16; n++) do_write(n, (5 + 4 * n) & 63);
    do_done(16, 0, 0, 0);
    check_all("t1.done");
    cyc();
    check_all("t1.wait");
    readback("t1");
    do_blk();
    check_all("t1.idle");

    // 2: out-of-order write dropped
    do_start(16);
    do_write(0, 1); do_write(1, 2); do_write(3, 7);
    check_all("t2");

    // 3: K_limit overflow
    do_start(4);
    for (int n = 0; n < 5; n++) do_write(n, 20 + n);
    check_all("t3");
    do_done(4, 0, 0, 0); cyc();
    readback("t3");

    // 4: duplicate index
    do_start(16);
    do_write(0, 12); do_write(1, 12);
    check_all("t4");

    // 5: write and done in the same cycle
    do_start(16);
    do_write(0, 3); do_write(1, 4);
    do_done(3, 1, 2, 5);
    check_all("t5.done");
    cyc(); do_blk();
    check_all("t5.idle");

    // 6: restart in WAIT_C, then async reset mid-collect
    do_start(16);
    do_write(0, 9); do_write(2, 9);
    do_done(5, 0, 0, 0); cyc();
    check_all("t6.wait");
    do_start(8);
    check_all("t6.restart");
    do_write(0, 33); do_write(1, 34);
    #2 rst = 1;
    #1;
    model_reset();
    check_all("t6.async");
    check("t6.async.rd", 32'(rd_data), 32'd0);
    #1 rst = 0;
    cyc();
    check_all("t6.post");

    // K_limit = 0: empty handoff
    do_start(0);
    do_write(0, 1);
    do_done(0, 0, 0, 0);
    check_all("k0");
    cyc(); do_blk();

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      k = $urandom_range(0, 20);
      do_start(k);
      nw = $urandom_range(0, 20);
      for (int w = 0; w < nw; w++) begin
        r = $urandom_range(0, 9);
        i = (r == 0) ? $urandom_range(0, 31) : m_cnt;
        idx = $urandom_range(0, 63);
        if (r == 1 && m_tbl.size() > 0) idx = m_tbl[0];
        if (r == 2) do_blk();
        do_write(i, idx);
        check_all($sformatf("r%0d.w", s));
      end
      we = $urandom_range(0, 1);
      fi = m_cnt + $urandom_range(0, 1);
      do_done(fi, we, m_cnt, $urandom_range(0, 63));
      check_all($sformatf("r%0d.done", s));
      cyc();
      do_write(m_cnt, 1);
      check_all($sformatf("r%0d.wc", s));
      readback($sformatf("r%0d", s));
      if ($urandom_range(0, 1)) begin
        do_blk();
        check_all($sformatf("r%0d.idle", s));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
